gmac_rx_frame_buffer: RTL
=========================

# gmac_rx_frame_buffer

Store-and-forward receive frame buffer directly downstream of the GMAC receive payload port (SOF/EOF/ENA/ERR/DATA stream). It writes each incoming payload into a circular byte RAM and commits the frame only when EOF arrives with no error. Bad, truncated, oversized or non-fitting frames are rolled back. Committed frames are replayed to the application over a valid/ready byte stream, with the frame length available from the first byte.

## Interface
- ADDR_W, 11: log2 of payload RAM depth in bytes (2048).
- LEN_AW, 2: log2 of length-FIFO depth (max 4 committed frames pending).
- MAX_LEN, 1500: largest accepted payload in bytes.
- clk125  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- DATA_IN  in  8  payload byte from the GMAC.
- ENA_IN  in  1  byte strobe; DATA_IN valid.
- SOF_IN  in  1  first byte of frame; qualified by ENA_IN.
- EOF_IN  in  1  last byte of frame; qualified by ENA_IN.
- ERR_IN  in  1  frame error (CRC etc.); any cycle from SOF beat to EOF beat inclusive, ENA-independent.
- m_data  out  8  output byte.
- m_valid  out  1  m_data valid.
- m_ready  in  1  consumer accepts byte.
- m_sof  out  1  first byte of frame.
- m_eof  out  1  last byte of frame.
- m_len  out  16  byte count of current output frame; stable from the m_sof beat through the m_eof transfer.
- frm_ok_cnt  out  16  committed frames, wraps.
- frm_drop_cnt  out  16  dropped frames, wraps.

## Operation
- Pointers: wr_ptr, commit_ptr and rd_ptr are ADDR_W+1 bits, modulo 2^(ADDR_W+1).
  - used = wr_ptr - rd_ptr.
  - A byte fits iff used < 2^ADDR_W.
- Write FSM: W_IDLE, W_RECV, W_DROP. Per-frame counter wcnt (16 b), error flag werr.
- W_IDLE:
  - ENA_IN & SOF_IN: write the byte, wcnt=1, werr=ERR_IN.
    - If EOF_IN is also high, evaluate commit at once (single-byte frame).
    - Otherwise go to W_RECV.
  - ENA_IN without SOF_IN: ignored, not counted.
- W_RECV, on ENA_IN:
  - SOF_IN high: roll back (wr_ptr=commit_ptr), drop count +1, then treat the beat as a new SOF from W_IDLE.
  - Byte does not fit, or wcnt would exceed MAX_LEN: roll back, drop +1, go to W_DROP. If the beat is EOF, go to W_IDLE instead.
  - Otherwise write the byte and increment wcnt; werr |= ERR_IN.
- Commit at EOF beat:
  - Condition: werr|ERR_IN == 0 and the length FIFO is not full.
  - Action: push wcnt (including the EOF byte) to the length FIFO, commit_ptr = wr_ptr after the write, frm_ok_cnt +1, go to W_IDLE.
  - Failure: roll back, frm_drop_cnt +1, go to W_IDLE.
- W_DROP: discard until ENA_IN & EOF_IN → W_IDLE. ENA_IN & SOF_IN → new frame as from W_IDLE; no extra drop count.
- Read FSM: R_IDLE, R_LOAD, R_SEND.
  - R_IDLE: when the length FIFO is non-empty, pop it into m_len/rcnt and issue a RAM read at rd_ptr → R_LOAD.
  - R_LOAD: output register filled; m_valid=1, m_sof=1 → R_SEND.
  - R_SEND: on m_valid&m_ready, rd_ptr +1 and rcnt -1. The next byte is prefetched so m_valid stays high with no bubble inside a frame.
  - m_eof=1 when rcnt==1. The transfer with m_eof returns to R_IDLE, or pops the next length directly if the FIFO is non-empty.
- The reader only ever reads committed bytes (rd_ptr never passes commit_ptr).
- Simultaneous commit and pop on the length FIFO is legal; occupancy is unchanged.
- Mid-operation reset: all frames, partial and committed, are discarded.

## Timing
- Reset values:
  - m_valid, m_sof, m_eof: 0.
  - m_data, m_len: 0.
  - Counters: 0.
  - Pointers: 0.
  - FSMs: W_IDLE, R_IDLE.
- Latency: EOF beat accepted at edge N, read side idle → m_valid&m_sof high after edge N+3.
- With a frame already committed, the next frame's first byte is valid no later than 2 cycles after the previous m_eof transfer.
- Once asserted, m_valid, m_data, m_sof and m_eof hold until the transfer.
- m_ready is ignored while m_valid=0.
- RAM is single-clock, one write and one read port, with registered read.
- Counters update on the edge following the EOF/SOF/overflow beat.

## Test plan
- Good frame: 64 bytes 0x00..0x3F, ERR_IN=0, m_ready=1 → m_len=64, identical bytes, m_sof on 0x00, m_eof on 0x3F, m_valid first high at EOF edge+3, frm_ok_cnt=1.
- ERR_IN pulsed on the EOF beat of a 100-byte frame, followed by a 10-byte good frame → only the 10-byte frame is output (m_len=10), frm_drop_cnt=1, frm_ok_cnt=1.
- Back-pressure: m_ready toggling 1/0 every cycle over a 1-byte frame then a 1500-byte frame → all bytes in order, no duplicates or bubbles beyond m_ready; m_len 1 then 1500.
- Overflow: m_ready=0, send 1500 B good (fits), then 1000 B (does not fit) → second dropped, drop=1; after draining, a third 1000 B frame is committed.
- Length FIFO full: m_ready=0, five 16-byte good frames → four committed, fifth dropped; MAX_LEN+1 byte frame → dropped.
- SOF inside a frame after 20 bytes, then a 30-byte frame ending in EOF → only the 30-byte frame is output, drop=1. Reset asserted mid-output → all outputs return to reset values immediately.

Source files
------------

// File: rtl/gmac_rx_frame_buffer.sv
// Store-and-forward receive buffer: GMAC payload bytes are written to a circular RAM,
// committed on a clean EOF, and replayed as a valid/ready byte stream with the frame length.
module gmac_rx_frame_buffer #(
    parameter int ADDR_W  = 11,
    parameter int LEN_AW  = 2,
    parameter int MAX_LEN = 1500
) (
    input  logic        clk125,
    input  logic        rst_n,
    input  logic [7:0]  DATA_IN,
    input  logic        ENA_IN,
    input  logic        SOF_IN,
    input  logic        EOF_IN,
    input  logic        ERR_IN,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_sof,
    output logic        m_eof,
    output logic [15:0] m_len,
    output logic [15:0] frm_ok_cnt,
    output logic [15:0] frm_drop_cnt
);

    localparam int PW = ADDR_W + 1;
    localparam int LW = LEN_AW + 1;
    localparam logic [PW-1:0] RAM_DEPTH = PW'(2 ** ADDR_W);
    localparam logic [LW-1:0] LF_DEPTH  = LW'(2 ** LEN_AW);
    localparam logic [15:0]   MAX_LEN_W = 16'(MAX_LEN);

    typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_LOAD, R_SEND} r_state_t;

    logic [7:0]        ram [2 ** ADDR_W];
    logic [7:0]        ram_q;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr, ram_raddr, rd_a;

    logic [PW-1:0] wr_ptr, wr_ptr_n, commit_ptr, commit_ptr_n, rd_ptr;
    logic          fits_wr, fits_base;
    w_state_t      w_state, w_state_n;
    logic [15:0]   wcnt, wcnt_n, commit_len;
    logic          werr, werr_n, commit, start;
    logic [1:0]    drop_inc;

    logic [15:0]       lf_mem [2 ** LEN_AW];
    logic [LEN_AW-1:0] lf_wp, lf_rp;
    logic [LW-1:0]     lf_avail, lf_occ, lf_occ_tot;
    logic              lf_full, push_q;
    logic [15:0]       push_len;

    r_state_t    r_state, r_state_n;
    logic [15:0] rcnt;
    logic        xfer, last_xfer, load;

    assign fits_wr    = (wr_ptr - rd_ptr) < RAM_DEPTH;
    assign fits_base  = (commit_ptr - rd_ptr) < RAM_DEPTH;
    assign rd_a       = rd_ptr[ADDR_W-1:0];
    // A frame occupies its length slot from commit until its last byte is transferred
    assign lf_occ_tot = lf_occ + LW'(push_q);
    assign lf_full    = lf_occ_tot >= LF_DEPTH;
    assign xfer       = m_valid && m_ready;
    assign last_xfer  = xfer && m_eof;

    always_comb begin
        w_state_n    = w_state;
        wr_ptr_n     = wr_ptr;
        commit_ptr_n = commit_ptr;
        wcnt_n       = wcnt;
        werr_n       = werr;
        ram_we       = 1'b0;
        ram_waddr    = wr_ptr[ADDR_W-1:0];
        commit       = 1'b0;
        commit_len   = wcnt + 16'd1;
        drop_inc     = 2'd0;
        start        = 1'b0;
        case (w_state)
            W_IDLE: if (ENA_IN && SOF_IN) start = 1'b1;
            W_DROP: begin
                if (ENA_IN && SOF_IN)      start = 1'b1;
                else if (ENA_IN && EOF_IN) w_state_n = W_IDLE;
            end
            W_RECV: begin
                werr_n = werr | ERR_IN;
                if (ENA_IN) begin
                    if (SOF_IN) begin
                        drop_inc = 2'd1;
                        start    = 1'b1;
                    end else if (!fits_wr || wcnt >= MAX_LEN_W) begin
                        drop_inc  = 2'd1;
                        wr_ptr_n  = commit_ptr;
                        w_state_n = EOF_IN ? W_IDLE : W_DROP;
                    end else begin
                        ram_we   = 1'b1;
                        wr_ptr_n = wr_ptr + PW'(1);
                        wcnt_n   = wcnt + 16'd1;
                        if (EOF_IN) begin
                            w_state_n = W_IDLE;
                            if (!(werr | ERR_IN) && !lf_full) begin
                                commit       = 1'b1;
                                commit_ptr_n = wr_ptr + PW'(1);
                            end else begin
                                drop_inc = 2'd1;
                                wr_ptr_n = commit_ptr;
                            end
                        end
                    end
                end
            end
            default: w_state_n = W_IDLE;
        endcase

        // A new frame always begins at commit_ptr, which also rolls back any partial frame
        if (start) begin
            ram_waddr  = commit_ptr[ADDR_W-1:0];
            commit_len = 16'd1;
            if (!fits_base) begin
                drop_inc  = drop_inc + 2'd1;
                wr_ptr_n  = commit_ptr;
                w_state_n = EOF_IN ? W_IDLE : W_DROP;
            end else begin
                ram_we   = 1'b1;
                wr_ptr_n = commit_ptr + PW'(1);
                wcnt_n   = 16'd1;
                werr_n   = ERR_IN;
                if (EOF_IN) begin
                    w_state_n = W_IDLE;
                    if (!ERR_IN && !lf_full) begin
                        commit       = 1'b1;
                        commit_ptr_n = commit_ptr + PW'(1);
                    end else begin
                        drop_inc = drop_inc + 2'd1;
                        wr_ptr_n = commit_ptr;
                    end
                end else begin
                    w_state_n = W_RECV;
                end
            end
        end
    end

    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            w_state      <= W_IDLE;
            wr_ptr       <= '0;
            commit_ptr   <= '0;
            wcnt         <= '0;
            werr         <= 1'b0;
            push_q       <= 1'b0;
            push_len     <= '0;
            frm_ok_cnt   <= '0;
            frm_drop_cnt <= '0;
        end else begin
            w_state      <= w_state_n;
            wr_ptr       <= wr_ptr_n;
            commit_ptr   <= commit_ptr_n;
            wcnt         <= wcnt_n;
            werr         <= werr_n;
            push_q       <= commit;
            if (commit) push_len <= commit_len;
            frm_ok_cnt   <= frm_ok_cnt + 16'(commit);
            frm_drop_cnt <= frm_drop_cnt + 16'(drop_inc);
        end
    end

    always_ff @(posedge clk125) begin
        if (ram_we) ram[ram_waddr] <= DATA_IN;
        ram_q <= ram[ram_raddr];
    end

    always_ff @(posedge clk125) begin
        if (push_q) lf_mem[lf_wp] <= push_len;
    end

    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            lf_wp    <= '0;
            lf_rp    <= '0;
            lf_avail <= '0;
            lf_occ   <= '0;
        end else begin
            if (push_q) lf_wp <= lf_wp + 1'b1;
            if (load)   lf_rp <= lf_rp + 1'b1;
            lf_avail <= lf_avail + LW'(push_q) - LW'(load);
            lf_occ   <= lf_occ + LW'(push_q) - LW'(last_xfer);
        end
    end

    // ram_q always prefetches the byte after the one held in m_data
    always_comb begin
        r_state_n = r_state;
        load      = 1'b0;
        ram_raddr = rd_a + ADDR_W'(1);
        case (r_state)
            R_IDLE: begin
                ram_raddr = rd_a;
                if (lf_avail != '0) begin
                    load      = 1'b1;
                    r_state_n = R_LOAD;
                end
            end
            R_LOAD: r_state_n = R_SEND;
            R_SEND: begin
                if (xfer) begin
                    if (m_eof) begin
                        if (lf_avail != '0) begin
                            load      = 1'b1;
                            r_state_n = R_LOAD;
                        end else begin
                            r_state_n = R_IDLE;
                        end
                    end else begin
                        ram_raddr = rd_a + ADDR_W'(2);
                    end
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            rd_ptr  <= '0;
            rcnt    <= '0;
            m_len   <= '0;
            m_data  <= '0;
            m_valid <= 1'b0;
            m_sof   <= 1'b0;
            m_eof   <= 1'b0;
        end else begin
            r_state <= r_state_n;
            if (r_state == R_LOAD) begin
                m_data  <= ram_q;
                m_valid <= 1'b1;
                m_sof   <= 1'b1;
                m_eof   <= (rcnt == 16'd1);
            end
            if (xfer) begin
                rd_ptr <= rd_ptr + PW'(1);
                rcnt   <= rcnt - 16'd1;
                m_sof  <= 1'b0;
                if (m_eof) begin
                    m_valid <= 1'b0;
                    m_eof   <= 1'b0;
                end else begin
                    m_data <= ram_q;
                    m_eof  <= (rcnt == 16'd2);
                end
            end
            if (load) begin
                m_len <= lf_mem[lf_rp];
                rcnt  <= lf_mem[lf_rp];
            end
        end
    end

endmodule
